vga_sprite_renderer: RTL and testbench

VGA_SPRITE_RENDERER -- requirements
Module: vga_sprite_renderer

---
 rtl/vga_sprite_renderer_if.sv | 36 +++
 rtl/vga_sprite_renderer.sv | 169 ++++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sprite_renderer_if.sv
// Bundles the per-frame geometry, pixel coordinate and colour/collision outputs.
// The renderer takes the slave side; the pixel-timing source takes the master side.
interface vga_sprite_renderer_if #(
    parameter int NUM_OBS = 4
);
    logic                   frame_start;
    logic [9:0]             player_x;
    logic [9:0]             player_height;
    logic [10*NUM_OBS-1:0]  obs_x;
    logic [10*NUM_OBS-1:0]  obs_y;
    logic [10*NUM_OBS-1:0]  obs_w;
    logic [10*NUM_OBS-1:0]  obs_h;
    logic [NUM_OBS-1:0]     obs_en;
    logic [9:0]             x;
    logic [9:0]             y;
    logic                   active_pixels;
    logic [7:0]             VGA_R;
    logic [7:0]             VGA_G;
    logic [7:0]             VGA_B;
    logic                   collision;
    logic                   collision_valid;

    modport master (
        output frame_start, player_x, player_height,
        output obs_x, obs_y, obs_w, obs_h, obs_en,
        output x, y, active_pixels,
        input  VGA_R, VGA_G, VGA_B, collision, collision_valid
    );

    modport slave (
        input  frame_start, player_x, player_height,
        input  obs_x, obs_y, obs_w, obs_h, obs_en,
        input  x, y, active_pixels,
        output VGA_R, VGA_G, VGA_B, collision, collision_valid
    );
endinterface

// File: rtl/vga_sprite_renderer.sv
// Two-stage sprite renderer: one player box plus NUM_OBS rectangular obstacles,
// geometry latched once per frame, with per-frame player/obstacle overlap report.
module vga_sprite_renderer #(
    parameter int          NUM_OBS     = 4,
    parameter int          BOX_WIDTH   = 30,
    parameter int          BOX_Y_START = 315,
    parameter logic [23:0] C_PLAYER    = 24'h0000FF,
    parameter logic [23:0] C_OBS       = 24'hFF0000,
    parameter logic [23:0] C_BG        = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_sprite_renderer_if.slave  bus
);

    // Geometry comparisons run at 11 bits so that right/bottom edges past 1023 clip.
    localparam logic [10:0] BOX_W11 = 11'(BOX_WIDTH);
    localparam logic [10:0] BOX_Y11 = 11'(BOX_Y_START);

    // Half-open span test: start <= pos < start + len, with the sum kept at 11 bits.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] start,
                                     input logic [10:0] len);
        logic [10:0] end_v;
        end_v = {1'b0, start} + len;
        return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < end_v);
    endfunction

    // Per-frame shadow copies of the geometry
    logic [9:0]            px_q;
    logic [9:0]            ph_q;
    logic [10*NUM_OBS-1:0] ox_q;
    logic [10*NUM_OBS-1:0] oy_q;
    logic [10*NUM_OBS-1:0] ow_q;
    logic [10*NUM_OBS-1:0] oh_q;
    logic [NUM_OBS-1:0]    en_q;

    // Stage 1 / stage 2 pipeline and collision state
    logic                  player_hit_s;
    logic [NUM_OBS-1:0]    obs_hit_s;
    logic [10:0]           top_s;
    logic                  player_hit_q;
    logic [NUM_OBS-1:0]    obs_hit_q;
    logic                  act_q;
    logic [23:0]           rgb_d;
    logic [23:0]           rgb_q;
    logic                  overlap_s;
    logic                  hit_frame_q;
    logic                  collision_q;
    logic                  collision_valid_q;

    // Latch all geometry on frame_start so mid-frame input changes are invisible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= 10'd0;
            ph_q <= 10'd0;
            ox_q <= '0;
            oy_q <= '0;
            ow_q <= '0;
            oh_q <= '0;
            en_q <= '0;
        end else if (bus.frame_start) begin
            px_q <= bus.player_x;
            ph_q <= bus.player_height;
            ox_q <= bus.obs_x;
            oy_q <= bus.obs_y;
            ow_q <= bus.obs_w;
            oh_q <= bus.obs_h;
            en_q <= bus.obs_en;
        end else begin
            px_q <= px_q;
            ph_q <= ph_q;
            ox_q <= ox_q;
            oy_q <= oy_q;
            ow_q <= ow_q;
            oh_q <= oh_q;
            en_q <= en_q;
        end
    end

    // Player hit: box hangs upward from BOX_Y_START; a tall box clamps its top at row 0
    always_comb begin
        top_s        = 11'd0;
        player_hit_s = 1'b0;
        if ({1'b0, ph_q} > BOX_Y11) begin
            top_s = 11'd0;
        end else begin
            top_s = BOX_Y11 - {1'b0, ph_q} + 11'd1;
        end
        if (ph_q == 10'd0) begin
            player_hit_s = 1'b0;
        end else begin
            player_hit_s = in_span(bus.x, px_q, BOX_W11)
                         && ({1'b0, bus.y} >= top_s)
                         && ({1'b0, bus.y} <= BOX_Y11);
        end
    end

    // Obstacle hits: zero width or height naturally yields an empty span
    always_comb begin
        obs_hit_s = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_hit_s[i] = en_q[i]
                && in_span(bus.x, ox_q[10*i +: 10], {1'b0, ow_q[10*i +: 10]})
                && in_span(bus.y, oy_q[10*i +: 10], {1'b0, oh_q[10*i +: 10]});
        end
    end

    // Stage 1: register hit flags alongside the delayed visible-area flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_hit_q <= 1'b0;
            obs_hit_q    <= '0;
            act_q        <= 1'b0;
        end else begin
            player_hit_q <= player_hit_s;
            obs_hit_q    <= obs_hit_s;
            act_q        <= bus.active_pixels;
        end
    end

    // Colour select: blanking forces black, obstacles win over the player
    always_comb begin
        rgb_d = 24'h000000;
        if (!act_q) begin
            rgb_d = 24'h000000;
        end else if (|obs_hit_q) begin
            rgb_d = C_OBS;
        end else if (player_hit_q) begin
            rgb_d = C_PLAYER;
        end else begin
            rgb_d = C_BG;
        end
    end

    // Stage 2: registered pixel colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign overlap_s = player_hit_q & (|obs_hit_q) & act_q;

    // Sticky per-frame overlap; on frame_start report it and restart, a same-cycle overlap seeds the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_frame_q       <= 1'b0;
            collision_q       <= 1'b0;
            collision_valid_q <= 1'b0;
        end else if (bus.frame_start) begin
            collision_q       <= hit_frame_q;
            collision_valid_q <= 1'b1;
            hit_frame_q       <= overlap_s;
        end else begin
            collision_q       <= collision_q;
            collision_valid_q <= 1'b0;
            hit_frame_q       <= hit_frame_q | overlap_s;
        end
    end

    assign bus.VGA_R           = rgb_q[23:16];
    assign bus.VGA_G           = rgb_q[15:8];
    assign bus.VGA_B           = rgb_q[7:0];
    assign bus.collision       = collision_q;
    assign bus.collision_valid = collision_valid_q;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer with a frame-level reference model.
module tb_vga_sprite_renderer;

    localparam int NOBS = 4;
    localparam int BW   = 30;
    localparam int BYS  = 315;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   cmp_en;

    vga_sprite_renderer_if #(.NUM_OBS(NOBS)) bus ();

    vga_sprite_renderer #(.NUM_OBS(NOBS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (frame-level arithmetic) ----------------
    int m_px, m_ph;
    int m_ox[NOBS], m_oy[NOBS], m_ow[NOBS], m_oh[NOBS];
    bit m_en[NOBS];
    logic [23:0] m_c1, m_rgb;
    bit m_ov1, m_hitf, m_coll, m_cv;

    function automatic bit model_player(int xx, int yy);
        int top;
        if (m_ph == 0) return 1'b0;
        top = BYS - m_ph + 1;
        if (top < 0) top = 0;
        return (xx >= m_px) && (xx < m_px + BW) && (yy >= top) && (yy <= BYS);
    endfunction

    function automatic bit model_obs(int xx, int yy);
        bit any;
        any = 1'b0;
        for (int i = 0; i < NOBS; i++)
            if (m_en[i] && xx >= m_ox[i] && xx < m_ox[i] + m_ow[i]
                        && yy >= m_oy[i] && yy < m_oy[i] + m_oh[i])
                any = 1'b1;
        return any;
    endfunction

    function automatic logic [23:0] model_color(int xx, int yy, bit act);
        if (!act) return 24'h000000;
        if (model_obs(xx, yy)) return RED;
        if (model_player(xx, yy)) return BLUE;
        return WHITE;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_px <= 0; m_ph <= 0;
            for (int i = 0; i < NOBS; i++) begin
                m_ox[i] <= 0; m_oy[i] <= 0; m_ow[i] <= 0; m_oh[i] <= 0; m_en[i] <= 1'b0;
            end
            m_c1 <= 24'h0; m_rgb <= 24'h0; m_ov1 <= 1'b0;
            m_hitf <= 1'b0; m_coll <= 1'b0; m_cv <= 1'b0;
        end else begin
            m_rgb <= m_c1;
            m_c1  <= model_color(int'(bus.x), int'(bus.y), bus.active_pixels);
            m_ov1 <= bus.active_pixels && model_player(int'(bus.x), int'(bus.y))
                                       && model_obs(int'(bus.x), int'(bus.y));
            if (bus.frame_start) begin
                m_coll <= m_hitf;
                m_cv   <= 1'b1;
                m_hitf <= m_ov1;
                m_px   <= int'(bus.player_x);
                m_ph   <= int'(bus.player_height);
                for (int i = 0; i < NOBS; i++) begin
                    m_ox[i] <= int'(bus.obs_x[10*i +: 10]);
                    m_oy[i] <= int'(bus.obs_y[10*i +: 10]);
                    m_ow[i] <= int'(bus.obs_w[10*i +: 10]);
                    m_oh[i] <= int'(bus.obs_h[10*i +: 10]);
                    m_en[i] <= bus.obs_en[i];
                end
            end else begin
                m_cv   <= 1'b0;
                m_hitf <= m_hitf | m_ov1;
            end
        end
    end

    // Continuous compare on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== m_rgb) begin
                failures++;
                $display("FAIL model_rgb t=%0t got=%h exp=%h", $time,
                         {bus.VGA_R, bus.VGA_G, bus.VGA_B}, m_rgb);
            end
            checks++;
            if ({bus.collision, bus.collision_valid} !== {m_coll, m_cv}) begin
                failures++;
                $display("FAIL model_coll t=%0t got=%b%b exp=%b%b", $time,
                         bus.collision, bus.collision_valid, m_coll, m_cv);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    task automatic probe(input int xx, input int yy, input logic [23:0] exp);
        bus.x = 10'(xx); bus.y = 10'(yy); bus.active_pixels = 1'b1;
        cyc();
        bus.active_pixels = 1'b0;
        cyc();
        chk($sformatf("pix_%0d_%0d", xx, yy), rgb(), {8'h00, exp});
    endtask

    task automatic frame_pulse(input bit exp_coll);
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
        chk("cv_high", {31'd0, bus.collision_valid}, 32'd1);
        chk("coll_val", {31'd0, bus.collision}, {31'd0, exp_coll});
        cyc();
        chk("cv_low", {31'd0, bus.collision_valid}, 32'd0);
    endtask

    task automatic set_obs(input int i, input int ox, input int oy, input int ow, input int oh);
        bus.obs_x[10*i +: 10] = 10'(ox);
        bus.obs_y[10*i +: 10] = 10'(oy);
        bus.obs_w[10*i +: 10] = 10'(ow);
        bus.obs_h[10*i +: 10] = 10'(oh);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++) begin
                bus.x = 10'(xx); bus.y = 10'(yy); bus.active_pixels = 1'b1;
                cyc();
            end
        bus.active_pixels = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        checks = 0; failures = 0; cmp_en = 1'b0;
        rst_n = 1'b0;
        bus.frame_start = 1'b0; bus.player_x = 10'd0; bus.player_height = 10'd0;
        bus.obs_x = '0; bus.obs_y = '0; bus.obs_w = '0; bus.obs_h = '0; bus.obs_en = '0;
        bus.x = 10'd0; bus.y = 10'd0; bus.active_pixels = 1'b0;
        repeat (3) cyc();
        chk("rst_rgb", rgb(), 32'd0);
        chk("rst_coll", {30'd0, bus.collision, bus.collision_valid}, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cyc();

        // nothing drawn before the first frame_start
        probe(100, 300, WHITE);

        // player only
        bus.player_x = 10'd100; bus.player_height = 10'd30;
        frame_pulse(1'b0);
        probe(99, 300, WHITE);
        probe(100, 300, BLUE);
        probe(129, 300, BLUE);
        probe(130, 300, WHITE);
        probe(100, 286, BLUE);
        probe(100, 285, WHITE);
        probe(100, 315, BLUE);
        probe(100, 316, WHITE);
        bus.x = 10'd110; bus.y = 10'd300; bus.active_pixels = 1'b0;
        cyc(); cyc();
        chk("blank_black", rgb(), 32'd0);

        // obstacle 0 overlapping the player
        set_obs(0, 110, 290, 20, 20);
        bus.obs_en = 4'b0001;
        frame_pulse(1'b0);
        probe(115, 300, RED);
        probe(105, 300, BLUE);
        probe(125, 309, RED);
        probe(125, 310, BLUE);
        scan(95, 135, 285, 320);
        frame_pulse(1'b1);

        // mid-frame geometry change is ignored until the next frame_start
        set_obs(0, 400, 290, 20, 20);
        probe(115, 300, RED);
        probe(405, 300, WHITE);
        frame_pulse(1'b1);
        probe(115, 300, BLUE);
        probe(405, 300, RED);
        probe(419, 300, RED);
        probe(420, 300, WHITE);

        // right-edge clipping, no wrap to column 0
        set_obs(3, 1020, 290, 10, 20);
        bus.obs_en = 4'b1001;
        frame_pulse(1'b0);
        probe(1019, 300, WHITE);
        probe(1020, 300, RED);
        probe(1023, 300, RED);
        for (int xx = 0; xx <= 5; xx++) probe(xx, 300, WHITE);

        // zero-height and over-tall player
        bus.player_height = 10'd0;
        frame_pulse(1'b0);
        probe(100, 300, WHITE);
        probe(110, 315, WHITE);
        bus.player_height = 10'd400;
        frame_pulse(1'b0);
        probe(100, 0, BLUE);
        probe(129, 315, BLUE);
        probe(100, 316, WHITE);
        probe(130, 0, WHITE);

        // disabled obstacles neither draw nor collide
        bus.player_height = 10'd30;
        set_obs(0, 110, 290, 20, 20);
        bus.obs_en = 4'b0000;
        frame_pulse(1'b0);
        scan(95, 135, 285, 320);
        probe(115, 300, BLUE);
        frame_pulse(1'b0);

        // back-to-back frame_start pulses each strobe collision_valid
        bus.frame_start = 1'b1;
        cyc();
        chk("b2b_cv1", {31'd0, bus.collision_valid}, 32'd1);
        cyc();
        bus.frame_start = 1'b0;
        chk("b2b_cv2", {31'd0, bus.collision_valid}, 32'd1);
        cyc();
        chk("b2b_cv3", {31'd0, bus.collision_valid}, 32'd0);

        // overlap coinciding with frame_start lands in the new frame
        bus.obs_en = 4'b0001;
        frame_pulse(1'b0);
        bus.x = 10'd115; bus.y = 10'd300; bus.active_pixels = 1'b1;
        cyc();
        bus.active_pixels = 1'b0;
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
        chk("sw_coll_old", {31'd0, bus.collision}, 32'd0);
        repeat (2) cyc();
        frame_pulse(1'b1);

        // asynchronous reset mid-scan
        bus.x = 10'd115; bus.y = 10'd300; bus.active_pixels = 1'b1;
        cyc(); cyc();
        chk("pre_rst_red", rgb(), {8'h00, RED});
        rst_n = 1'b0;
        #1;
        chk("async_rgb", rgb(), 32'd0);
        chk("async_coll", {30'd0, bus.collision, bus.collision_valid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("post_rst_bg", rgb(), {8'h00, WHITE});
        bus.active_pixels = 1'b0;
        probe(100, 300, WHITE);
        frame_pulse(1'b0);
        probe(115, 300, RED);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
